// File: rtl/ray_pkg.sv
// Shared constants for the camera ray generator: ray vector layout, IEEE-754
// double constants and the scan controller states.
package ray_pkg;
  localparam int VEC_W = 192;
  localparam int DBL_W = 64;
  localparam int X_LSB = 128;
  localparam int Y_LSB = 64;
  localparam int Z_LSB = 0;
  localparam logic [63:0] DBL_NEG_ONE = 64'hBFF0000000000000;
  localparam int DBL_BIAS = 1023;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/int_to_double.sv
// Exact conversion of a small signed integer, scaled by 2^-SCALE_LOG2, into an
// IEEE-754 double. Inputs are narrow enough that no rounding is ever needed.
module int_to_double
  import ray_pkg::*;
#(
  parameter int IN_W       = 11,
  parameter int SCALE_LOG2 = 8
) (
  input  logic signed [IN_W-1:0]  val,
  output logic        [DBL_W-1:0] dbl
);

  logic [IN_W-1:0] mag;
  logic [IN_W-2:0] norm;
  logic [51:0]     mant;
  logic [10:0]     expo;
  int              msb;

  always_comb begin
    mag = val[IN_W-1] ? $unsigned(-val) : $unsigned(val);
    msb = 0;
    for (int k = 0; k < IN_W; k++) begin
      if (mag[k]) msb = k;
    end
    // The cast drops the implicit leading one after normalisation.
    norm = (IN_W-1)'(mag << (IN_W - 1 - msb));
    mant = '0;
    mant[51 -: IN_W-1] = norm;
    expo = 11'(DBL_BIAS + msb - SCALE_LOG2);
    dbl  = (mag == '0) ? '0 : {val[IN_W-1], expo, mant};
  end

endmodule

// File: rtl/ray_gen.sv
// Camera ray source: scans the frame top row first and presents one primary-ray
// direction per pixel on a valid/ready interface.
module ray_gen
  import ray_pkg::*;
#(
  parameter int LOG2_W = 8,
  parameter int LOG2_H = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ray_valid,
  input  logic              ray_ready,
  output logic [VEC_W-1:0]  ray_dir,
  output logic [LOG2_W-1:0] pix_x,
  output logic [LOG2_H-1:0] pix_y,
  output logic              last
);

  localparam logic [LOG2_W-1:0] X_MAX = '1;
  localparam logic [LOG2_H-1:0] Y_TOP = '1;
  localparam int X_OFF = 2 << LOG2_W;
  localparam int Y_OFF = 1 << LOG2_H;

  state_t                    state;
  logic [LOG2_W-1:0]         nx;
  logic [LOG2_H-1:0]         ny;
  logic                      n_last;
  logic                      hs;
  logic signed [LOG2_W+2:0]  xi;
  logic signed [LOG2_H+1:0]  yi;
  logic [DBL_W-1:0]          xd;
  logic [DBL_W-1:0]          yd;

  assign hs = ray_valid && ray_ready;

  // Next pixel to present: the frame origin from IDLE, otherwise the successor.
  always_comb begin
    nx = '0;
    ny = Y_TOP;
    if (state == RUN) begin
      if (pix_x == X_MAX) begin
        nx = '0;
        ny = pix_y - LOG2_H'(1);
      end else begin
        nx = pix_x + LOG2_W'(1);
        ny = pix_y;
      end
    end
    n_last = (nx == X_MAX) && (ny == '0);
    xi = {1'b0, nx, 2'b00} - (LOG2_W+3)'(X_OFF);
    yi = {1'b0, ny, 1'b0} - (LOG2_H+2)'(Y_OFF);
  end

  int_to_double #(.IN_W(LOG2_W+3), .SCALE_LOG2(LOG2_W)) u_x (.val(xi), .dbl(xd));
  int_to_double #(.IN_W(LOG2_H+2), .SCALE_LOG2(LOG2_H)) u_y (.val(yi), .dbl(yd));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ray_valid <= 1'b0;
      last      <= 1'b0;
      ray_dir   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state                     <= RUN;
            busy                      <= 1'b1;
            ray_valid                 <= 1'b1;
            pix_x                     <= nx;
            pix_y                     <= ny;
            last                      <= n_last;
            ray_dir[X_LSB +: DBL_W]   <= xd;
            ray_dir[Y_LSB +: DBL_W]   <= yd;
            ray_dir[Z_LSB +: DBL_W]   <= DBL_NEG_ONE;
          end
        end
        RUN: begin
          if (hs) begin
            if (last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              ray_valid <= 1'b0;
              last      <= 1'b0;
              done      <= 1'b1;
            end else begin
              pix_x                   <= nx;
              pix_y                   <= ny;
              last                    <= n_last;
              ray_dir[X_LSB +: DBL_W] <= xd;
              ray_dir[Y_LSB +: DBL_W] <= yd;
              ray_dir[Z_LSB +: DBL_W] <= DBL_NEG_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_gen.sv
// Scoreboard bench for ray_gen: a 4x2 instance for protocol scenarios and a
// default 256x128 instance for one full frame, both checked against a real-valued model.
module tb_ray_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_s, ready_s = 1'b1, busy_s, done_s, valid_s, last_s;
  logic [191:0] dir_s;
  logic [1:0]   px_s;
  logic [0:0]   py_s;
  logic         start_d, ready_d, busy_d, done_d, valid_d, last_d;
  logic [191:0] dir_d;
  logic [7:0]   px_d;
  logic [6:0]   py_d;

  ray_gen #(.LOG2_W(2), .LOG2_H(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .ray_valid(valid_s), .ray_ready(ready_s), .ray_dir(dir_s),
    .pix_x(px_s), .pix_y(py_s), .last(last_s)
  );

  ray_gen dut_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .busy(busy_d), .done(done_d),
    .ray_valid(valid_d), .ray_ready(ready_d), .ray_dir(dir_d),
    .pix_x(px_d), .pix_y(py_d), .last(last_d)
  );

  typedef struct {
    logic [191:0] dir;
    int           x;
    int           y;
    bit           last;
  } ray_t;

  ray_t q_s[$];
  ray_t q_d[$];
  int   checks = 0;
  int   errors = 0;
  int   fin_s = 0;
  int   fin_d = 0;
  int   hs_s = 0;
  bit   rnd_en = 1'b0;
  bit   ready_fix = 1'b1;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  // Reference: dir = (-2 + 4i/W, -1 + 2j/H, -1) evaluated in real arithmetic.
  function automatic logic [191:0] ref_dir(input int i, input int j, input int lw, input int lh);
    real w, h;
    w = real'(1 << lw);
    h = real'(1 << lh);
    return {$realtobits(-2.0 + 4.0 * i / w), $realtobits(-1.0 + 2.0 * j / h), $realtobits(-1.0)};
  endfunction

  task automatic push_frame(input bit dflt);
    int lw, lh;
    ray_t r;
    lw = dflt ? 8 : 2;
    lh = dflt ? 7 : 1;
    for (int j = (1 << lh) - 1; j >= 0; j--) begin
      for (int i = 0; i < (1 << lw); i++) begin
        r.dir  = ref_dir(i, j, lw, lh);
        r.x    = i;
        r.y    = j;
        r.last = (i == (1 << lw) - 1) && (j == 0);
        if (dflt) q_d.push_back(r);
        else      q_s.push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fin(input bit dflt, input int tgt, input int budget);
    int n;
    n = 0;
    while (((dflt ? fin_d : fin_s) < tgt) && (n < budget)) begin
      tick();
      n++;
    end
    if ((dflt ? fin_d : fin_s) < tgt) fail(dflt ? "done_timeout_d" : "done_timeout_s");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ready_s = rnd_en ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Monitor for the small instance: ordering, hold rule, busy and done.
  initial begin : mon_s
    logic [191:0] h_dir;
    logic [3:0]   h_pix;
    bit           stall, fexp;
    ray_t         e;
    stall = 1'b0;
    fexp  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        fexp  = 1'b0;
      end else begin
        chk("done_s", 192'(done_s), 192'(fexp));
        if (done_s) fin_s++;
        chk("busy_s", 192'(busy_s), 192'(valid_s));
        if (stall) begin
          chk("hold_valid_s", 192'(valid_s), 192'(1));
          chk("hold_dir_s", dir_s, h_dir);
          chk("hold_pix_s", 192'({px_s, py_s, last_s}), 192'(h_pix));
        end
        fexp = 1'b0;
        if (valid_s && ready_s) begin
          hs_s++;
          if (q_s.size() == 0) begin
            fail("extra_ray_s");
          end else begin
            e = q_s.pop_front();
            chk("dir_s", dir_s, e.dir);
            chk("pix_x_s", 192'(px_s), 192'(e.x));
            chk("pix_y_s", 192'(py_s), 192'(e.y));
            chk("last_s", 192'(last_s), 192'(e.last));
            fexp = e.last;
          end
        end
        stall = valid_s && !ready_s;
        h_dir = dir_s;
        h_pix = {px_s, py_s, last_s};
      end
    end
  end

  initial begin : mon_d
    bit   fexp;
    ray_t e;
    fexp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fexp = 1'b0;
      end else begin
        chk("done_d", 192'(done_d), 192'(fexp));
        if (done_d) fin_d++;
        chk("busy_d", 192'(busy_d), 192'(valid_d));
        fexp = 1'b0;
        if (valid_d && ready_d) begin
          if (q_d.size() == 0) begin
            fail("extra_ray_d");
          end else begin
            e = q_d.pop_front();
            chk("dir_d", dir_d, e.dir);
            chk("pix_d", 192'({px_d, py_d}), 192'({8'(e.x), 7'(e.y)}));
            chk("last_d", 192'(last_d), 192'(e.last));
            fexp = e.last;
          end
        end
      end
    end
  end

  initial begin
    int n, tgt, base;
    rst_n = 1'b0; start_s = 1'b0; start_d = 1'b0; ready_d = 1'b1;
    tick(); tick();
    chk("rst_ctrl_s", 192'({valid_s, busy_s, done_s, last_s}), 192'(0));
    chk("rst_data_s", dir_s | 192'({px_s, py_s}), 192'(0));
    chk("rst_ctrl_d", 192'({valid_d, busy_d, done_d, last_d}), 192'(0));
    chk("rst_data_d", dir_d | 192'({px_d, py_d}), 192'(0));
    rst_n = 1'b1;
    tick();

    // Full default frame at full rate.
    tgt = fin_d + 1;
    push_frame(1'b1);
    start_d = 1'b1; tick(); start_d = 1'b0;
    chk("first_valid_d", 192'(valid_d), 192'(1));
    chk("first_x_d", 192'(dir_d[191:128]), 192'(64'hC000000000000000));
    chk("first_y_d", 192'(dir_d[127:64]), 192'(64'h3FEF800000000000));
    n = 0;
    while (!last_d && n < 40000) begin tick(); n++; end
    if (!last_d) fail("last_timeout_d");
    else begin
      chk("final_x_d", 192'(dir_d[191:128]), 192'(64'h3FFFC00000000000));
      chk("final_y_d", 192'(dir_d[127:64]), 192'(64'hBFF0000000000000));
      chk("final_pix_d", 192'({px_d, py_d}), 192'({8'd255, 7'd0}));
    end
    wait_fin(1'b1, tgt, 40000);

    // Small frame, ready held high.
    tgt = fin_s + 1;
    push_frame(1'b0);
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("latency_valid_s", 192'(valid_s), 192'(1));
    chk("latency_pix_s", 192'({px_s, py_s}), 192'({2'd0, 1'd1}));
    wait_fin(1'b0, tgt, 50);

    // Restart in the done cycle.
    tgt = fin_s + 2;
    push_frame(1'b0);
    start_s = 1'b1; tick(); start_s = 1'b0;
    n = 0;
    while (!done_s && n < 50) begin tick(); n++; end
    if (!done_s) fail("done_wait_s");
    else begin
      push_frame(1'b0);
      start_s = 1'b1; tick(); start_s = 1'b0;
      chk("restart_valid_s", 192'(valid_s), 192'(1));
      chk("restart_pix_s", 192'({px_s, py_s}), 192'({2'd0, 1'd1}));
    end
    wait_fin(1'b0, tgt, 50);

    // Start pulsed while running must not restart the scan.
    tgt = fin_s + 1;
    push_frame(1'b0);
    start_s = 1'b1; tick(); start_s = 1'b0;
    tick(); tick();
    start_s = 1'b1; tick(); start_s = 1'b0;
    wait_fin(1'b0, tgt, 50);
    tick(); tick(); tick();
    chk("run_start_ignored_q", 192'(q_s.size()), 192'(0));
    chk("run_start_ignored_v", 192'(valid_s), 192'(0));

    // Reset mid-frame after three rays.
    base = hs_s;
    push_frame(1'b0);
    start_s = 1'b1; tick(); start_s = 1'b0;
    n = 0;
    while (hs_s < base + 3 && n < 50) begin tick(); n++; end
    if (hs_s < base + 3) fail("hs_wait_s");
    rst_n = 1'b0;
    q_s.delete();
    tick();
    chk("midrst_ctrl_s", 192'({valid_s, busy_s, done_s, last_s}), 192'(0));
    chk("midrst_data_s", dir_s | 192'({px_s, py_s}), 192'(0));
    rst_n = 1'b1;
    tick(); tick();
    chk("midrst_no_done_s", 192'({done_s, valid_s}), 192'(0));

    // First frame after reset under ten stalled cycles.
    ready_fix = 1'b0;
    tick(); tick();
    tgt = fin_s + 1;
    push_frame(1'b0);
    start_s = 1'b1; tick(); start_s = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("stall_ctrl_s", 192'({valid_s, busy_s}), 192'(2'b11));
      chk("stall_pix_s", 192'({px_s, py_s}), 192'({2'd0, 1'd1}));
      chk("stall_x_s", 192'(dir_s[191:128]), 192'(64'hC000000000000000));
      tick();
    end
    ready_fix = 1'b1;
    wait_fin(1'b0, tgt, 50);

    // Random backpressure with occasional start pulses mid-frame.
    rnd_en = 1'b1;
    for (int f = 0; f < 15; f++) begin
      tgt = fin_s + 1;
      push_frame(1'b0);
      start_s = 1'b1; tick(); start_s = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        tick();
        start_s = 1'b1; tick(); start_s = 1'b0;
      end
      wait_fin(1'b0, tgt, 300);
    end
    rnd_en = 1'b0;
    tick(); tick(); tick();
    chk("queue_empty_s", 192'(q_s.size()), 192'(0));
    chk("queue_empty_d", 192'(q_d.size()), 192'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
